ipm2l_hsstlp_pll_lock_mon_v1_0: RTL and testbench
=================================================

// Module: ipm2l_hsstlp_pll_lock_mon_v1_0
// PURPOSE
//  Consumer side of the HSSTLP PLL reset handshake. Synchronises the raw PLL lock and qualifies it
//  once the PLL reset FSM reports done. On loss of lock or failure to qualify, it re-runs the FSM by
//  pulsing that FSM's rst_n. Sits between the HSST PLL lock pin, the PLL reset FSM and the lane reset logic.
// PARAMETERS
//  FREE_CLOCK_FREQ  100  free clock freq, MHz
//  LOCK_QUAL_US     10   continuous lock time to qualify, us; QUAL_CNT = LOCK_QUAL_US*FREE_CLOCK_FREQ (<=16383)
//  UNLOCK_FILT      4    consecutive low sync-lock cycles that count as loss of lock (>=1)
//  RST_PULSE        16   o_pll_fsm_rst_n low time, clk cycles (>=2)
//  RETRY_MAX        3    consecutive restarts before declaring failure (1..15)
// PORTS
//  clk               in   1   free-running clock
//  rst_n             in   1   reset; asynchronous, active-low
//  i_pll_lock_raw    in   1   PLL lock from HSST, asynchronous to clk
//  i_pll_done        in   1   o_pll_done of PLL reset FSM
//  o_pll_fsm_rst_n   out  1   active-low reset to PLL reset FSM
//  o_pll_lock_sync   out  1   synchronised lock
//  o_pll_lock_stable out  1   qualified lock; lane resets may release
//  o_pll_fail        out  1   sticky: RETRY_MAX restarts exhausted
//  o_lol_cnt         out  8   loss-of-lock event count (IPM2L_HSSTLP_LOL_CNT_EN only)
// BEHAVIOUR
//  Reset: state WAIT, all counters 0, o_pll_fsm_rst_n=0, other outputs 0. All outputs registered.
//  Sync: 2-flop synchroniser; o_pll_lock_sync follows i_pll_lock_raw 2 clk later.
//  cntr 16 bit: saturates, never wraps. retry 4 bit.
//  Edges of rst_n: o_pll_fsm_rst_n goes 1 on the first clk after rst_n rises.
//  States:
//   WAIT: o_pll_fsm_rst_n=1.
//         Leave: i_pll_done=1 -> QUAL, cntr cleared.
//   QUAL: cntr counts up every cycle. qcnt counts lock_sync=1 cycles; lock_sync=0 clears qcnt.
//         Leave (priority order):
//          i_pll_done=0 -> WAIT.
//          qcnt==QUAL_CNT-1 with lock_sync=1 -> STABLE. o_pll_lock_stable=1 next cycle; retry cleared.
//          cntr==4*QUAL_CNT-1 (timeout) -> RESTART.
//   STABLE: lcnt counts consecutive lock_sync=0 cycles; lock_sync=1 clears lcnt.
//         Leave (priority order):
//          i_pll_done=0 -> WAIT, o_pll_lock_stable=0 next cycle.
//          lcnt==UNLOCK_FILT-1 with lock_sync=0 -> RESTART, o_pll_lock_stable=0 next cycle.
//          This is a LOL event.
//         Glitches shorter than UNLOCK_FILT are ignored.
//   RESTART: o_pll_fsm_rst_n=0 for exactly RST_PULSE cycles, cntr counts them.
//         Entering RESTART: retry+1.
//         If retry reaches RETRY_MAX -> FAIL instead of restarting.
//         Leave: pulse end -> WAIT. i_pll_done is ignored here.
//   FAIL: o_pll_fail=1, o_pll_fsm_rst_n=1, o_pll_lock_stable=0. Terminal until rst_n.
//  Simultaneous events:
//   i_pll_done falls on the cycle qualification completes -> WAIT wins.
//   Lock loss on the same cycle i_pll_done falls -> WAIT, no retry, no LOL count.
//  Reset mid-operation: immediate return to reset values, including o_pll_fsm_rst_n=0.
// CONFIGURATION
//  IPM2L_HSSTLP_LOL_CNT_EN defined:
//   o_lol_cnt increments on each STABLE->RESTART event and saturates at 255.
//   It clears only on rst_n.
//  Undefined: port present, tied 8'd0, no counter flops.
// STRUCTURE
//  Shared header ipm2l_hsstlp_rst_define.vh:
//   state encodings (WAIT=3'd0, QUAL=1, STABLE=2, RESTART=3, FAIL=4), CNTR_WIDTH=16.
//   The same header serves the PLL reset FSM and lane reset FSMs.
//  One sub-module, ipm2l_hsstlp_sync_v1_0: 2-flop synchroniser with async reset to 0.
//   Reused for lane signals.
// TESTING (FREE_CLOCK_FREQ=100, LOCK_QUAL_US=10 -> QUAL_CNT=1000, UNLOCK_FILT=4, RST_PULSE=16, RETRY_MAX=3)
//  1 Clean lock: lock_raw=1, then i_pll_done=1 at t0.
//    -> o_pll_lock_stable=1 at t0+1001..1003 cycles. o_pll_fsm_rst_n stays 1.
//  2 Glitch: in STABLE, lock_raw low for 3 cycles -> stable stays 1.
//    Low for 4 cycles -> stable=0, o_pll_fsm_rst_n low for exactly 16 cycles, o_lol_cnt=1 (macro on).
//  3 Dropout in QUAL: lock_raw low for 1 cycle at qcnt=500 -> qualification restarts.
//    Stable asserts 1000 cycles after lock returns.
//  4 No lock: lock_raw=0 with i_pll_done=1.
//    -> timeout after 4000 cycles, 3 restarts, then o_pll_fail=1 and FSM reset released.
//  5 i_pll_done drops in STABLE -> WAIT, stable=0 next cycle, no restart pulse, retry unchanged.
//  6 rst_n asserted during RESTART -> outputs at reset values same cycle.
//    Release -> o_pll_fsm_rst_n=1 one clk later. With macro off, o_lol_cnt=0 throughout.

Source files
------------

// File: rtl/ipm2l_hsstlp_pll_lock_mon_v1_0_pkg.sv
// ============================================================================
// Module  : ipm2l_hsstlp_pll_lock_mon_v1_0_pkg
// Brief   : Reset-handshake definitions shared by the HSSTLP PLL reset FSM,
//           the PLL lock monitor and the lane reset FSMs: state encodings,
//           counter width and a saturating increment helper.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ipm2l_hsstlp_pll_lock_mon_v1_0_pkg;

  // Common width of the handshake timers (cntr/qcnt/lcnt)
  localparam int CNTR_WIDTH = 16;

  // Shared reset-handshake state encoding
  typedef enum logic [2:0] {
    ST_WAIT    = 3'd0,
    ST_QUAL    = 3'd1,
    ST_STABLE  = 3'd2,
    ST_RESTART = 3'd3,
    ST_FAIL    = 3'd4
  } rst_state_e;

  // Timers saturate at all-ones so a stuck condition can never wrap back
  // into a spurious compare match.
  function automatic logic [CNTR_WIDTH-1:0] sat_inc(input logic [CNTR_WIDTH-1:0] v);
    return (&v) ? v : v + CNTR_WIDTH'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ipm2l_hsstlp_sync_v1_0.sv
// ============================================================================
// Module  : ipm2l_hsstlp_sync_v1_0
// Brief   : Two-flop synchroniser, asynchronous active-low reset to 0.
//           Used for the PLL lock pin and for lane status signals.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ipm2l_hsstlp_sync_v1_0 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two register stages to resolve metastability on the asynchronous input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/ipm2l_hsstlp_pll_lock_mon_v1_0.sv
// ============================================================================
// Module  : ipm2l_hsstlp_pll_lock_mon_v1_0
// Brief   : PLL lock monitor. Synchronises the raw HSST PLL lock, qualifies
//           it once the PLL reset FSM reports done, and re-runs that FSM by
//           pulsing its rst_n on loss of lock or qualification timeout.
//           Gives up (sticky o_pll_fail) after RETRY_MAX restarts in a row.
// Config  : IPM2L_HSSTLP_LOL_CNT_EN - when defined, o_lol_cnt counts
//           loss-of-lock events (saturating at 255); otherwise tied to 0.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ipm2l_hsstlp_pll_lock_mon_v1_0
  import ipm2l_hsstlp_pll_lock_mon_v1_0_pkg::*;
#(
  parameter int FREE_CLOCK_FREQ = 100,
  parameter int LOCK_QUAL_US    = 10,
  parameter int UNLOCK_FILT     = 4,
  parameter int RST_PULSE       = 16,
  parameter int RETRY_MAX       = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_pll_lock_raw,
  input  logic       i_pll_done,
  output logic       o_pll_fsm_rst_n,
  output logic       o_pll_lock_sync,
  output logic       o_pll_lock_stable,
  output logic       o_pll_fail,
  output logic [7:0] o_lol_cnt
);

  localparam int QUAL_CNT = LOCK_QUAL_US * FREE_CLOCK_FREQ;

  // Terminal counts, each compared against the count of the current cycle
  localparam logic [CNTR_WIDTH-1:0] QUAL_LAST    = CNTR_WIDTH'(QUAL_CNT - 1);
  localparam logic [CNTR_WIDTH-1:0] TIMEOUT_LAST = CNTR_WIDTH'(4 * QUAL_CNT - 1);
  localparam logic [CNTR_WIDTH-1:0] UNLOCK_LAST  = CNTR_WIDTH'(UNLOCK_FILT - 1);
  localparam logic [CNTR_WIDTH-1:0] PULSE_LAST   = CNTR_WIDTH'(RST_PULSE - 1);
  localparam logic [3:0]            RETRY_LIM    = 4'(RETRY_MAX);

  logic                  lock_sync;

  rst_state_e            state_q,  state_d;
  logic [CNTR_WIDTH-1:0] cntr_q,   cntr_d;
  logic [CNTR_WIDTH-1:0] qcnt_q,   qcnt_d;
  logic [CNTR_WIDTH-1:0] lcnt_q,   lcnt_d;
  logic [3:0]            retry_q,  retry_d;
  logic                  restart_req;

  logic                  fsm_rst_n_q;
  logic                  stable_q;
  logic                  fail_q;

  ipm2l_hsstlp_sync_v1_0 #(
    .WIDTH (1)
  ) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (i_pll_lock_raw),
    .q_o   (lock_sync)
  );

  // State, timers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_WAIT;
      cntr_q      <= '0;
      qcnt_q      <= '0;
      lcnt_q      <= '0;
      retry_q     <= '0;
      fsm_rst_n_q <= 1'b0;
      stable_q    <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cntr_q      <= cntr_d;
      qcnt_q      <= qcnt_d;
      lcnt_q      <= lcnt_d;
      retry_q     <= retry_d;
      // Outputs are decoded from the next state so they line up with it
      fsm_rst_n_q <= (state_d != ST_RESTART);
      stable_q    <= (state_d == ST_STABLE);
      fail_q      <= (state_d == ST_FAIL);
    end
  end

  // Next-state and timer update; i_pll_done dropping always wins in QUAL/STABLE
  always_comb begin
    state_d     = state_q;
    cntr_d      = cntr_q;
    qcnt_d      = qcnt_q;
    lcnt_d      = lcnt_q;
    retry_d     = retry_q;
    restart_req = 1'b0;

    case (state_q)
      ST_WAIT: begin
        if (i_pll_done) begin
          state_d = ST_QUAL;
          cntr_d  = '0;
          qcnt_d  = '0;
        end
      end

      ST_QUAL: begin
        cntr_d = sat_inc(cntr_q);
        qcnt_d = lock_sync ? sat_inc(qcnt_q) : '0;
        if (!i_pll_done) begin
          state_d = ST_WAIT;
        end else if (lock_sync && (qcnt_q == QUAL_LAST)) begin
          state_d = ST_STABLE;
          lcnt_d  = '0;
          retry_d = '0;
        end else if (cntr_q == TIMEOUT_LAST) begin
          restart_req = 1'b1;
        end
      end

      ST_STABLE: begin
        lcnt_d = lock_sync ? '0 : sat_inc(lcnt_q);
        if (!i_pll_done) begin
          state_d = ST_WAIT;
        end else if (!lock_sync && (lcnt_q == UNLOCK_LAST)) begin
          restart_req = 1'b1;
        end
      end

      ST_RESTART: begin
        // i_pll_done is deliberately ignored while the FSM is held in reset
        cntr_d = sat_inc(cntr_q);
        if (cntr_q == PULSE_LAST) begin
          state_d = ST_WAIT;
        end
      end

      ST_FAIL: begin
        state_d = ST_FAIL;
      end

      default: begin
        state_d = ST_WAIT;
      end
    endcase

    // Restart budget: once RETRY_MAX pulses have been spent, stop retrying
    if (restart_req) begin
      if (retry_q >= RETRY_LIM) begin
        state_d = ST_FAIL;
      end else begin
        state_d = ST_RESTART;
        cntr_d  = '0;
        retry_d = retry_q + 4'd1;
      end
    end
  end

  assign o_pll_fsm_rst_n   = fsm_rst_n_q;
  assign o_pll_lock_sync   = lock_sync;
  assign o_pll_lock_stable = stable_q;
  assign o_pll_fail        = fail_q;

`ifdef IPM2L_HSSTLP_LOL_CNT_EN
  logic [7:0] lol_cnt_q;
  logic       lol_evt;

  assign lol_evt = (state_q == ST_STABLE) && (state_d == ST_RESTART);

  // Saturating loss-of-lock counter, cleared only by rst_n
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lol_cnt_q <= '0;
    end else if (lol_evt && (lol_cnt_q != 8'hFF)) begin
      lol_cnt_q <= lol_cnt_q + 8'd1;
    end
  end

  assign o_lol_cnt = lol_cnt_q;
`else
  assign o_lol_cnt = 8'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ipm2l_hsstlp_pll_lock_mon_v1_0.sv
// ============================================================================
// Module  : tb_ipm2l_hsstlp_pll_lock_mon_v1_0
// Brief   : Scoreboard bench for the PLL lock monitor. Each stimulus step
//           predicts, from the behavioural timing rules, on which clock edge
//           each output changes and to what value; a monitor process pops
//           the prediction whenever an output actually changes.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ipm2l_hsstlp_pll_lock_mon_v1_0;

  localparam int FREQ = 100;
  localparam int QUS  = 10;
  localparam int UF   = 4;
  localparam int RP   = 16;
  localparam int RM   = 3;
  localparam int Q    = QUS * FREQ;
  localparam int TO   = 4 * Q;

  localparam int F_STB  = 0;
  localparam int F_RSTN = 1;
  localparam int F_FAIL = 2;
  localparam int F_SYNC = 3;
  localparam int F_LOL  = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_pll_lock_raw;
  logic       i_pll_done;
  logic       o_pll_fsm_rst_n;
  logic       o_pll_lock_sync;
  logic       o_pll_lock_stable;
  logic       o_pll_fail;
  logic [7:0] o_lol_cnt;

  ipm2l_hsstlp_pll_lock_mon_v1_0 #(
    .FREE_CLOCK_FREQ (FREQ),
    .LOCK_QUAL_US    (QUS),
    .UNLOCK_FILT     (UF),
    .RST_PULSE       (RP),
    .RETRY_MAX       (RM)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_pll_lock_raw    (i_pll_lock_raw),
    .i_pll_done        (i_pll_done),
    .o_pll_fsm_rst_n   (o_pll_fsm_rst_n),
    .o_pll_lock_sync   (o_pll_lock_sync),
    .o_pll_lock_stable (o_pll_lock_stable),
    .o_pll_fail        (o_pll_fail),
    .o_lol_cnt         (o_lol_cnt)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int total = 0;
  int bad   = 0;
  int lol_exp = 0;
  bit mon_en = 1'b0;
  bit primed = 1'b0;

  typedef struct {
    int edge_i;
    int fld;
    int val;
  } exp_t;

  exp_t exp_q[$];
  int   prev_v[5];
  int   cur_v[5];

  function automatic string fname(input int f);
    case (f)
      F_STB:   return "stable";
      F_RSTN:  return "fsm_rst_n";
      F_FAIL:  return "fail";
      F_SYNC:  return "lock_sync";
      default: return "lol_cnt";
    endcase
  endfunction

  // Keep the expectation queue ordered by (edge, field)
  function automatic void push_exp(input int e, input int f, input int v);
    exp_t x;
    int   idx;
    x.edge_i = e;
    x.fld    = f;
    x.val    = v;
    idx = exp_q.size();
    while (idx > 0 && (exp_q[idx-1].edge_i > e ||
                      (exp_q[idx-1].edge_i == e && exp_q[idx-1].fld > f)))
      idx--;
    exp_q.insert(idx, x);
  endfunction

  task automatic chk(input string nm, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick_to(input int target);
    while (edge_n < target) tick(1);
  endtask

  // Monitor: every observed output change must match the next prediction
  initial begin
    forever begin
      @(negedge clk);
      cur_v[F_STB]  = int'(o_pll_lock_stable);
      cur_v[F_RSTN] = int'(o_pll_fsm_rst_n);
      cur_v[F_FAIL] = int'(o_pll_fail);
      cur_v[F_SYNC] = int'(o_pll_lock_sync);
      cur_v[F_LOL]  = int'(o_lol_cnt);
      if (mon_en) begin
        if (primed) begin
          while (exp_q.size() > 0 && exp_q[0].edge_i < edge_n) begin
            total++;
            bad++;
            $display("FAIL missed_%s edge=%0d got=%0d want=%0d at_edge=%0d",
                     fname(exp_q[0].fld), edge_n, cur_v[exp_q[0].fld],
                     exp_q[0].val, exp_q[0].edge_i);
            void'(exp_q.pop_front());
          end
          for (int f = 0; f < 5; f++) begin
            if (cur_v[f] != prev_v[f]) begin
              total++;
              if (exp_q.size() > 0 && exp_q[0].edge_i == edge_n && exp_q[0].fld == f) begin
                if (exp_q[0].val != cur_v[f]) begin
                  bad++;
                  $display("FAIL %s edge=%0d got=%0d want=%0d",
                           fname(f), edge_n, cur_v[f], exp_q[0].val);
                end
                void'(exp_q.pop_front());
              end else begin
                bad++;
                $display("FAIL unexpected_%s edge=%0d got=%0d want=%0d",
                         fname(f), edge_n, cur_v[f], prev_v[f]);
              end
            end
          end
        end
        primed = 1'b1;
        prev_v = cur_v;
      end
    end
  end

  // Short or long lock dropout while STABLE with i_pll_done held high
  task automatic glitch(input int len);
    int e;
    int f;
    e = edge_n;
    f = e + 2 + UF;
    i_pll_lock_raw = 1'b0;
    push_exp(e + 2, F_SYNC, 0);
    push_exp(e + len + 2, F_SYNC, 1);
    if (len >= UF) begin
      push_exp(f, F_STB, 0);
      push_exp(f, F_RSTN, 0);
`ifdef IPM2L_HSSTLP_LOL_CNT_EN
      lol_exp++;
      push_exp(f, F_LOL, lol_exp);
`endif
      push_exp(f + RP, F_RSTN, 1);
      push_exp(f + RP + 1 + Q, F_STB, 1);
    end
    tick(len);
    i_pll_lock_raw = 1'b1;
    if (len >= UF) tick_to(f + RP + 1 + Q + 3);
    else           tick(6);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_stable"},    int'(o_pll_lock_stable), 0);
    chk({tag, "_fsm_rst_n"}, int'(o_pll_fsm_rst_n),   0);
    chk({tag, "_fail"},      int'(o_pll_fail),        0);
    chk({tag, "_sync"},      int'(o_pll_lock_sync),   0);
    chk({tag, "_lol"},       int'(o_lol_cnt),         0);
  endtask

  initial begin
    int e;
    int s;
    int t;
    int f;
    int d;

    rst_n          = 1'b1;
    i_pll_lock_raw = 1'b0;
    i_pll_done     = 1'b0;
    #2 rst_n = 1'b0;
    tick(3);
    chk_reset_vals("reset");
    mon_en = 1'b1;
    tick(2);

    // Release: FSM reset goes high on the first clock
    e = edge_n;
    rst_n = 1'b1;
    push_exp(e + 1, F_RSTN, 1);
    tick(4);

    // Clean lock
    e = edge_n;
    i_pll_lock_raw = 1'b1;
    push_exp(e + 2, F_SYNC, 1);
    tick($urandom_range(3, 10));
    e = edge_n;
    i_pll_done = 1'b1;
    s = e + 1 + Q;
    push_exp(s, F_STB, 1);
    tick_to(s + 3);

    // Glitches around the unlock filter length
    glitch(UF - 1);
    glitch($urandom_range(1, UF - 1));
    glitch(UF);
    glitch($urandom_range(UF, UF + 3));

    // Lock loss on the same edge i_pll_done falls: WAIT, no restart
    e = edge_n;
    i_pll_lock_raw = 1'b0;
    push_exp(e + 2, F_SYNC, 0);
    f = e + 2 + UF;
    tick(f - 1 - e);
    i_pll_done = 1'b0;
    push_exp(f, F_STB, 0);
    tick(4);
    e = edge_n;
    i_pll_lock_raw = 1'b1;
    push_exp(e + 2, F_SYNC, 1);
    tick(4);

    // Single-cycle dropout in the middle of qualification
    e = edge_n;
    i_pll_done = 1'b1;
    d = $urandom_range(100, Q - 100);
    tick(d);
    e = edge_n;
    i_pll_lock_raw = 1'b0;
    push_exp(e + 2, F_SYNC, 0);
    push_exp(e + 3, F_SYNC, 1);
    tick(1);
    i_pll_lock_raw = 1'b1;
    s = e + 3 + Q;
    push_exp(s, F_STB, 1);
    tick_to(s + 3);

    // i_pll_done drops in STABLE: back to WAIT, no pulse
    e = edge_n;
    i_pll_done = 1'b0;
    push_exp(e + 1, F_STB, 0);
    tick($urandom_range(3, 8));

    // i_pll_done drops exactly on the qualifying edge: WAIT wins
    e = edge_n;
    i_pll_done = 1'b1;
    s = e + 1 + Q;
    tick_to(s - 1);
    i_pll_done = 1'b0;
    tick(5);

    // No lock: RM timeouts with restarts, then sticky failure
    e = edge_n;
    i_pll_lock_raw = 1'b0;
    push_exp(e + 2, F_SYNC, 0);
    tick(4);
    e = edge_n;
    i_pll_done = 1'b1;
    t = e + 1 + TO;
    for (int k = 0; k < RM; k++) begin
      push_exp(t, F_RSTN, 0);
      push_exp(t + RP, F_RSTN, 1);
      t = t + RP + 1 + TO;
    end
    push_exp(t, F_FAIL, 1);
    tick_to(t + 3);
    i_pll_done = 1'b0;
    tick(20);
    i_pll_done = 1'b1;
    e = edge_n;
    i_pll_lock_raw = 1'b1;
    push_exp(e + 2, F_SYNC, 1);
    tick(40);
    chk("fail_sticky",      int'(o_pll_fail),        1);
    chk("fail_fsm_rst_n",   int'(o_pll_fsm_rst_n),   1);
    chk("fail_stable",      int'(o_pll_lock_stable), 0);

    // Reset out of FAIL
    e = edge_n;
    rst_n = 1'b0;
    i_pll_done = 1'b0;
    push_exp(e, F_RSTN, 0);
    push_exp(e, F_FAIL, 0);
    push_exp(e, F_SYNC, 0);
    if (lol_exp != 0) push_exp(e, F_LOL, 0);
    lol_exp = 0;
    #1;
    chk_reset_vals("rst_from_fail");
    tick(3);
    e = edge_n;
    rst_n = 1'b1;
    push_exp(e + 1, F_RSTN, 1);
    push_exp(e + 2, F_SYNC, 1);
    tick(4);
    e = edge_n;
    i_pll_done = 1'b1;
    s = e + 1 + Q;
    push_exp(s, F_STB, 1);
    tick_to(s + 3);

    // Loss of lock, then reset asserted in the middle of the restart pulse
    e = edge_n;
    f = e + 2 + UF;
    i_pll_lock_raw = 1'b0;
    push_exp(e + 2, F_SYNC, 0);
    push_exp(e + 7, F_SYNC, 1);
    push_exp(f, F_STB, 0);
    push_exp(f, F_RSTN, 0);
`ifdef IPM2L_HSSTLP_LOL_CNT_EN
    lol_exp = 1;
    push_exp(f, F_LOL, 1);
`endif
    tick(5);
    i_pll_lock_raw = 1'b1;
    tick_to(f + 5);
    chk("restart_fsm_rst_n", int'(o_pll_fsm_rst_n), 0);
    chk("restart_lol",       int'(o_lol_cnt),       lol_exp);
    e = edge_n;
    rst_n = 1'b0;
    i_pll_done = 1'b0;
    push_exp(e, F_SYNC, 0);
    if (lol_exp != 0) push_exp(e, F_LOL, 0);
    lol_exp = 0;
    #1;
    chk_reset_vals("rst_in_restart");
    tick(3);
    e = edge_n;
    rst_n = 1'b1;
    push_exp(e + 1, F_RSTN, 1);
    push_exp(e + 2, F_SYNC, 1);
    tick(8);
    chk("final_fsm_rst_n", int'(o_pll_fsm_rst_n), 1);
    chk("final_lol",       int'(o_lol_cnt),       0);
    tick(3);

    while (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL pending_%s got=none want=%0d at_edge=%0d",
               fname(exp_q[0].fld), exp_q[0].val, exp_q[0].edge_i);
      void'(exp_q.pop_front());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
